// File: rtl/button_conditioner.sv
// Push-button conditioner: two-flop synchroniser, counter debouncer and a
// short/long press classifier producing registered single-cycle command pulses.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int HOLD_CYCLES     = 100000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic btn_level,
  output logic press,
  output logic short_press,
  output logic long_press
);

  localparam int DW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int HW = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    HELD    = 2'd2
  } state_t;

  logic          sync1_r;
  logic          sync2_r;
  logic [DW-1:0] deb_cnt_r;
  logic [HW-1:0] hold_cnt_r;
  logic [HW-1:0] hold_cnt_nxt_s;
  state_t        state_r;
  state_t        state_nxt_s;
  logic          deb_flip_s;
  logic          rise_s;
  logic          fall_s;
  logic          press_nxt_s;
  logic          short_nxt_s;
  logic          long_nxt_s;

  // Two-flop synchroniser for the asynchronous button
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= btn;
      sync2_r <= sync1_r;
    end
  end

  // The debounced level flips on the edge where the disagreement run completes;
  // the classifier sees that same edge as rise/fall.
  assign deb_flip_s = (sync2_r != btn_level) && (deb_cnt_r == DEB_LAST);
  assign rise_s     = deb_flip_s & sync2_r;
  assign fall_s     = deb_flip_s & ~sync2_r;

  // Debounce counter and level register
  always_ff @(posedge clk) begin
    if (rst) begin
      deb_cnt_r <= DW'(0);
      btn_level <= 1'b0;
    end else if (sync2_r == btn_level) begin
      deb_cnt_r <= DW'(0);
    end else if (deb_flip_s) begin
      deb_cnt_r <= DW'(0);
      btn_level <= sync2_r;
    end else begin
      deb_cnt_r <= deb_cnt_r + DW'(1);
    end
  end

  // Classifier next-state and pulse decode; a fall on the hold-completion edge wins
  always_comb begin
    state_nxt_s    = state_r;
    hold_cnt_nxt_s = hold_cnt_r;
    press_nxt_s    = 1'b0;
    short_nxt_s    = 1'b0;
    long_nxt_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (rise_s) begin
          state_nxt_s    = PRESSED;
          hold_cnt_nxt_s = HW'(0);
          press_nxt_s    = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      PRESSED: begin
        if (fall_s) begin
          state_nxt_s = IDLE;
          short_nxt_s = 1'b1;
        end else if (hold_cnt_r == HOLD_LAST) begin
          state_nxt_s = HELD;
          long_nxt_s  = 1'b1;
        end else begin
          hold_cnt_nxt_s = hold_cnt_r + HW'(1);
        end
      end
      HELD: begin
        if (fall_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = HELD;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Classifier state, hold counter and registered pulse outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      hold_cnt_r  <= HW'(0);
      press       <= 1'b0;
      short_press <= 1'b0;
      long_press  <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      hold_cnt_r  <= hold_cnt_nxt_s;
      press       <= press_nxt_s;
      short_press <= short_nxt_s;
      long_press  <= long_nxt_s;
    end
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner with a window/timestamp based
// reference model (DEBOUNCE_CYCLES=4, HOLD_CYCLES=20).
module tb_button_conditioner;

  localparam int D = 4;
  localparam int H = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn = 1'b0;
  logic btn_level, press, short_press, long_press;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  button_conditioner #(.DEBOUNCE_CYCLES(D), .HOLD_CYCLES(H)) dut (
    .clk(clk), .rst(rst), .btn(btn),
    .btn_level(btn_level), .press(press),
    .short_press(short_press), .long_press(long_press)
  );

  // Reference model: level changes once the last D samples seen by the
  // debouncer all disagree with it; pulses come from edge timestamps.
  int   ecnt = 0;
  logic q[$];
  logic seen[$];
  logic m_level = 1'b0, m_press = 1'b0, m_short = 1'b0, m_long = 1'b0;
  bit   pressing = 1'b0, long_done = 1'b0;
  int   rise_n = 0;

  always @(posedge clk) begin : model
    logic s2;
    bit   all_diff;
    ecnt++;
    m_press = 1'b0; m_short = 1'b0; m_long = 1'b0;
    if (rst) begin
      q = {1'b0, 1'b0};
      seen = {};
      m_level = 1'b0; pressing = 1'b0; long_done = 1'b0;
    end else begin
      s2 = q[q.size()-2];
      q.push_back(btn);
      if (q.size() > 2) void'(q.pop_front());
      seen.push_back(s2);
      if (seen.size() > D) void'(seen.pop_front());
      all_diff = (seen.size() == D);
      foreach (seen[i]) if (seen[i] == m_level) all_diff = 1'b0;
      if (all_diff) begin
        m_level = ~m_level;
        seen = {};
        if (m_level) begin
          m_press = 1'b1; rise_n = ecnt; pressing = 1'b1; long_done = 1'b0;
        end else begin
          if (pressing && !long_done) m_short = 1'b1;
          pressing = 1'b0;
        end
      end else if (pressing && !long_done && (ecnt - rise_n == H)) begin
        m_long = 1'b1; long_done = 1'b1;
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1; btn = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if ({btn_level, press, short_press, long_press} !== 4'b0000) begin
        errors++;
        $display("FAIL reset_state: edge %0d got %b want 0000", ecnt, {btn_level, press, short_press, long_press});
      end
    end
    rst = 1'b0;
    repeat (50) begin
      @(negedge clk);
      checks++;
      if ({btn_level, press, short_press, long_press} !== 4'b0000) begin
        errors++;
        $display("FAIL idle_low: edge %0d got %b want 0000", ecnt, {btn_level, press, short_press, long_press});
      end
    end
  endtask

  task automatic test_clean_press();
    int k, k2, rise_at, fall_at, np, ns, nl;
    rise_at = -1; fall_at = -1; np = 0; ns = 0; nl = 0;
    btn = 1'b1; k = ecnt + 1;
    for (int i = 0; i < 25; i++) begin
      if (i == 10) begin btn = 1'b0; k2 = ecnt + 1; end
      @(negedge clk);
      checks++;
      if ({btn_level, press, short_press, long_press} !== {m_level, m_press, m_short, m_long}) begin
        errors++;
        $display("FAIL clean_model: edge %0d got %b want %b", ecnt, {btn_level, press, short_press, long_press}, {m_level, m_press, m_short, m_long});
      end
      if (btn_level && rise_at < 0) rise_at = ecnt;
      if (!btn_level && rise_at >= 0 && fall_at < 0) fall_at = ecnt;
      np += press; ns += short_press; nl += long_press;
    end
    checks++;
    if (rise_at - k !== D + 1) begin errors++; $display("FAIL clean_rise_latency: got %0d want %0d", rise_at - k, D + 1); end
    checks++;
    if (fall_at - k2 !== D + 1) begin errors++; $display("FAIL clean_fall_latency: got %0d want %0d", fall_at - k2, D + 1); end
    checks++;
    if ({np, ns, nl} !== {32'd1, 32'd1, 32'd0}) begin errors++; $display("FAIL clean_pulse_counts: got p=%0d s=%0d l=%0d want 1 1 0", np, ns, nl); end
  endtask

  task automatic test_bounce();
    int highs, pulses, k, rise_at;
    highs = 0; pulses = 0; rise_at = -1;
    for (int i = 0; i < 30; i++) begin
      btn = ((i / 3) % 2 == 0);
      @(negedge clk);
      checks++;
      if ({btn_level, press, short_press, long_press} !== {m_level, m_press, m_short, m_long}) begin
        errors++;
        $display("FAIL bounce_model: edge %0d got %b want %b", ecnt, {btn_level, press, short_press, long_press}, {m_level, m_press, m_short, m_long});
      end
      highs += btn_level; pulses += press + short_press + long_press;
    end
    checks++;
    if ({highs, pulses} !== {32'd0, 32'd0}) begin errors++; $display("FAIL bounce_filtered: got highs=%0d pulses=%0d want 0 0", highs, pulses); end
    btn = 1'b1; k = ecnt + 1;
    for (int i = 0; i < 20; i++) begin
      if (i == 8) btn = 1'b0;
      @(negedge clk);
      if (btn_level && rise_at < 0) rise_at = ecnt;
    end
    checks++;
    if (rise_at - k !== D + 1) begin errors++; $display("FAIL bounce_then_stable: got %0d want %0d", rise_at - k, D + 1); end
  endtask

  task automatic test_long_hold();
    int rise_at, long_at, np, ns, nl;
    rise_at = -1; long_at = -1; np = 0; ns = 0; nl = 0;
    btn = 1'b1;
    for (int i = 0; i < 55; i++) begin
      if (i == 40) btn = 1'b0;
      @(negedge clk);
      checks++;
      if ({btn_level, press, short_press, long_press} !== {m_level, m_press, m_short, m_long}) begin
        errors++;
        $display("FAIL long_model: edge %0d got %b want %b", ecnt, {btn_level, press, short_press, long_press}, {m_level, m_press, m_short, m_long});
      end
      if (press) rise_at = ecnt;
      if (long_press) long_at = ecnt;
      np += press; ns += short_press; nl += long_press;
    end
    checks++;
    if (long_at - rise_at !== H) begin errors++; $display("FAIL long_timing: got %0d want %0d", long_at - rise_at, H); end
    checks++;
    if ({np, ns, nl, 31'd0, btn_level} !== {32'd1, 32'd0, 32'd1, 32'd0}) begin
      errors++; $display("FAIL long_counts: got p=%0d s=%0d l=%0d lvl=%b want 1 0 1 0", np, ns, nl, btn_level);
    end
  endtask

  task automatic test_fall_at_hold();
    int rise_at, fall_at, ns, nl;
    rise_at = -1; fall_at = -1; ns = 0; nl = 0;
    btn = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (i == H) btn = 1'b0;
      @(negedge clk);
      checks++;
      if ({btn_level, press, short_press, long_press} !== {m_level, m_press, m_short, m_long}) begin
        errors++;
        $display("FAIL fall_at_hold_model: edge %0d got %b want %b", ecnt, {btn_level, press, short_press, long_press}, {m_level, m_press, m_short, m_long});
      end
      if (press) rise_at = ecnt;
      if (short_press) fall_at = ecnt;
      ns += short_press; nl += long_press;
    end
    checks++;
    if ({ns, nl} !== {32'd1, 32'd0}) begin errors++; $display("FAIL fall_at_hold_wins: got s=%0d l=%0d want 1 0", ns, nl); end
    checks++;
    if (fall_at - rise_at !== H) begin errors++; $display("FAIL fall_at_hold_edge: got %0d want %0d", fall_at - rise_at, H); end
  endtask

  task automatic test_reset_mid();
    int k, rise_at, long_at, np, nl;
    rise_at = -1; long_at = -1; np = 0; nl = 0;
    btn = 1'b1;
    repeat (D + 2 + 8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({btn_level, press, short_press, long_press} !== 4'b0000) begin
      errors++; $display("FAIL reset_mid_clear: got %b want 0000", {btn_level, press, short_press, long_press});
    end
    repeat (2) @(negedge clk);
    rst = 1'b0; k = ecnt + 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      checks++;
      if ({btn_level, press, short_press, long_press} !== {m_level, m_press, m_short, m_long}) begin
        errors++;
        $display("FAIL reset_mid_model: edge %0d got %b want %b", ecnt, {btn_level, press, short_press, long_press}, {m_level, m_press, m_short, m_long});
      end
      if (press) rise_at = ecnt;
      if (long_press) long_at = ecnt;
      np += press; nl += long_press;
    end
    checks++;
    if (rise_at - k !== D + 1) begin errors++; $display("FAIL reset_mid_repress: got %0d want %0d", rise_at - k, D + 1); end
    checks++;
    if ({np, nl, long_at - rise_at} !== {32'd1, 32'd1, H}) begin
      errors++; $display("FAIL reset_mid_long: got p=%0d l=%0d dt=%0d want 1 1 %0d", np, nl, long_at - rise_at, H);
    end
    btn = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic test_random();
    int len;
    for (int b = 0; b < 60; b++) begin
      btn = $urandom_range(1, 0);
      len = $urandom_range(30, 1);
      repeat (len) begin
        @(negedge clk);
        checks++;
        if ({btn_level, press, short_press, long_press} !== {m_level, m_press, m_short, m_long}) begin
          errors++;
          $display("FAIL random_model: edge %0d got %b want %b", ecnt, {btn_level, press, short_press, long_press}, {m_level, m_press, m_short, m_long});
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_long_hold();
    test_fall_at_hold();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
